// File: rtl/pwm_3ip_pkg.sv
// Shared constants and types for the three-channel PWM core.
package pwm_3ip_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_CNT_W  = 16;

  localparam int GEN_BIT = 31;
  localparam int EN_LSB  = 16;

  // Duty is sized for the widest counter the 16-bit period field allows.
  typedef struct packed {
    logic                 en;
    logic [DEF_CNT_W-1:0] duty;
  } ch_cfg_t;

endpackage

// File: rtl/pwm_3ch_core_if.sv
// Configuration bus from the AXI-Lite register slave into the PWM core.
interface pwm_3ch_core_if
  import pwm_3ip_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [31:0]             cfg_ctrl;
  logic [NUM_CH*CNT_W-1:0] cfg_duty;
  logic                    cfg_wr;

  modport master (output cfg_ctrl, output cfg_duty, output cfg_wr);
  modport slave  (input  cfg_ctrl, input  cfg_duty, input  cfg_wr);

endinterface

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: compares the shared counter with this channel's duty.
module pwm_cmp_ch
  import pwm_3ip_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             run,
  input  ch_cfg_t          cfg,
  output logic             pwm
);

  logic [DEF_CNT_W-1:0] cnt_ext;

  assign cnt_ext = DEF_CNT_W'(cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= run && cfg.en && (cnt_ext < cfg.duty);
    end
  end

endmodule

// File: rtl/pwm_3ch_core.sv
// Multi-channel PWM core: period counter, double-buffered configuration and period tick.
// CNT_W must not exceed 16, the width of the period field in cfg_ctrl.
module pwm_3ch_core
  import pwm_3ip_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  pwm_3ch_core_if.slave     cfg,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic              upd_pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stg_period;
  logic [CNT_W-1:0] act_period;
  logic             stg_gen;
  logic             act_gen;
  logic             running;
  logic             wrap;
  logic             apply;

  assign running = act_gen && (act_period != '0);
  assign wrap    = running && (cnt == act_period - CNT_W'(1));
  // A write landing on the wrap cycle wins over the copy and waits for the next wrap.
  assign apply   = upd_pending && !cfg.cfg_wr && (wrap || !running);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stg_period  <= '0;
      stg_gen     <= 1'b0;
      upd_pending <= 1'b0;
    end else if (cfg.cfg_wr) begin
      stg_period  <= cfg.cfg_ctrl[CNT_W-1:0];
      stg_gen     <= cfg.cfg_ctrl[GEN_BIT];
      upd_pending <= 1'b1;
    end else if (apply) begin
      upd_pending <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      act_period <= '0;
      act_gen    <= 1'b0;
    end else if (apply) begin
      act_period <= stg_period;
      act_gen    <= stg_gen;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || wrap || !running) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_cfg_t stg_ch;
    ch_cfg_t act_ch;

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        stg_ch <= '0;
      end else if (cfg.cfg_wr) begin
        stg_ch.en   <= cfg.cfg_ctrl[EN_LSB+i];
        stg_ch.duty <= DEF_CNT_W'(cfg.cfg_duty[i*CNT_W +: CNT_W]);
      end
    end

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        act_ch <= '0;
      end else if (apply) begin
        act_ch <= stg_ch;
      end
    end

    pwm_cmp_ch #(
      .CNT_W (CNT_W)
    ) u_cmp (
      .clk (ACLK),
      .rst (ARESET),
      .cnt (cnt),
      .run (running),
      .cfg (act_ch),
      .pwm (pwm_out[i])
    );
  end

endmodule
